// File: rtl/video_pkg.sv
// video_pkg: pattern enum, 1080p active-area constants and the color-bar palette
package video_pkg;
   typedef enum logic [1:0] {
      PAT_SOLID   = 2'd0,
      PAT_BARS    = 2'd1,
      PAT_CHECKER = 2'd2,
      PAT_RAMP    = 2'd3
   } pattern_t;
   localparam int H_ACTIVE = 1920;
   localparam int V_ACTIVE = 1080;
   localparam logic [7:0][23:0] BAR_RGB = {
      24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
      24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
   };
endpackage

// File: rtl/pixel_coord.sv
// pixel_coord: stage-1 x/y/bar counters; outputs describe the pixel sampled on the previous cycle
module pixel_coord #(
   parameter int H_ACTIVE = 1920,
   parameter int V_ACTIVE = 1080,
   parameter int BAR_W    = 240
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_de_i,
   input  logic        in_vs_i,
   output logic [11:0] x_o,
   output logic [11:0] y_o,
   output logic [2:0]  bar_o
);
   import video_pkg::*;
   logic        de_q, run;
   logic [11:0] x_q, x_d, y_q, y_d, pib_q, pib_d;
   logic [2:0]  bar_q, bar_d;
   // Next-state: first DE cycle restarts at 0, x saturates, y counts DE falling edges
   always_comb begin
      run   = in_de_i && de_q;
      x_d   = !run ? '0 : (x_q == 12'(H_ACTIVE - 1)) ? x_q : x_q + 12'd1;
      pib_d = (!run || pib_q == 12'(BAR_W - 1)) ? '0 : pib_q + 12'd1;
      bar_d = !run ? '0 : (pib_q == 12'(BAR_W - 1)) ? bar_q + 3'd1 : bar_q;
      y_d   = !in_vs_i ? '0 : (de_q && !in_de_i && y_q != 12'(V_ACTIVE - 1)) ? y_q + 12'd1 : y_q;
   end
   // Counter state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         de_q  <= 1'b0;
         x_q   <= '0;
         y_q   <= '0;
         pib_q <= '0;
         bar_q <= '0;
      end else begin
         de_q  <= in_de_i;
         x_q   <= x_d;
         y_q   <= y_d;
         pib_q <= pib_d;
         bar_q <= bar_d;
      end
   end
   assign x_o   = x_q;
   assign y_o   = y_q;
   assign bar_o = bar_q;
endmodule

// File: rtl/hdmi_pattern_gen.sv
// hdmi_pattern_gen: 2-stage test-pattern generator (solid/bars/checker/ramp); HDMI_PATTERN_MOTION_EN adds frame-count scroll
module hdmi_pattern_gen #(
   parameter int H_ACTIVE = video_pkg::H_ACTIVE,
   parameter int V_ACTIVE = video_pkg::V_ACTIVE,
   parameter int BAR_W    = 240,
   parameter int CHK_LOG2 = 6
) (
   input  logic        hdmi_clk,
   input  logic        reset,
   input  logic        in_de,
   input  logic        in_hs,
   input  logic        in_vs,
   input  logic        next_frame,
   input  logic [1:0]  pattern_sel,
   input  logic [23:0] solid_rgb,
   output logic        out_de,
   output logic        out_hs,
   output logic        out_vs,
   output logic [7:0]  out_r,
   output logic [7:0]  out_g,
   output logic [7:0]  out_b
);
   import video_pkg::*;
   pattern_t    pat_q;
   logic        de1_q, hs1_q, vs1_q, de2_q, hs2_q, vs2_q, chk_black;
   logic [11:0] x, y, xo;
   logic [2:0]  bar;
   logic [7:0]  frame_cnt;
   logic [23:0] color, rgb_q;
   pixel_coord #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .BAR_W(BAR_W)) u_coord (
      .clk    (hdmi_clk),
      .reset  (reset),
      .in_de_i(in_de),
      .in_vs_i(in_vs),
      .x_o    (x),
      .y_o    (y),
      .bar_o  (bar)
   );
`ifdef HDMI_PATTERN_MOTION_EN
   logic [7:0] fc_q;
   // Frame counter advances once per frame and wraps naturally at 8 bits
   always_ff @(posedge hdmi_clk) fc_q <= reset ? 8'd0 : next_frame ? fc_q + 8'd1 : fc_q;
   assign frame_cnt = fc_q;
`else
   assign frame_cnt = 8'd0;
`endif
   // Pattern request only takes effect at the frame boundary
   always_ff @(posedge hdmi_clk) pat_q <= reset ? PAT_SOLID : next_frame ? pattern_t'(pattern_sel) : pat_q;
   // Color for the pixel held in stage 1
   always_comb begin
      xo        = x + {3'd0, frame_cnt, 1'b0};
      chk_black = |((xo ^ y) & (12'd1 << CHK_LOG2));
      color     = pat_q == PAT_SOLID   ? solid_rgb :
                  pat_q == PAT_BARS    ? BAR_RGB[bar] :
                  pat_q == PAT_CHECKER ? (chk_black ? 24'h000000 : 24'hFFFFFF) :
                                         {x[7:0], y[7:0], frame_cnt};
   end
   // Two-stage timing delay; color is blanked outside delayed DE
   always_ff @(posedge hdmi_clk) begin
      if (reset) begin
         de1_q <= 1'b0;
         hs1_q <= 1'b1;
         vs1_q <= 1'b1;
         de2_q <= 1'b0;
         hs2_q <= 1'b1;
         vs2_q <= 1'b1;
         rgb_q <= '0;
      end else begin
         de1_q <= in_de;
         hs1_q <= in_hs;
         vs1_q <= in_vs;
         de2_q <= de1_q;
         hs2_q <= hs1_q;
         vs2_q <= vs1_q;
         rgb_q <= de1_q ? color : 24'h000000;
      end
   end
   assign out_de = de2_q;
   assign out_hs = hs2_q;
   assign out_vs = vs2_q;
   assign {out_r, out_g, out_b} = rgb_q;
endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// tb_hdmi_pattern_gen: directed self-checking bench for hdmi_pattern_gen (HDMI_PATTERN_MOTION_EN aware)
module tb_hdmi_pattern_gen;
`ifdef HDMI_PATTERN_MOTION_EN
   localparam bit MOTION = 1'b1;
`else
   localparam bit MOTION = 1'b0;
`endif
   logic        clk = 1'b0;
   logic        reset, in_de, in_hs, in_vs, next_frame;
   logic [1:0]  pattern_sel;
   logic [23:0] solid_rgb, rgb;
   logic        out_de, out_hs, out_vs;
   logic [7:0]  out_r, out_g, out_b;
   logic [23:0] pix [2048];
   int          npix, bad;
   int          checks = 0;
   int          errors = 0;
   int          nf_cnt = 0;

   always #5 clk = ~clk;
   assign rgb = {out_r, out_g, out_b};

   hdmi_pattern_gen dut (
      .hdmi_clk   (clk),
      .reset      (reset),
      .in_de      (in_de),
      .in_hs      (in_hs),
      .in_vs      (in_vs),
      .next_frame (next_frame),
      .pattern_sel(pattern_sel),
      .solid_rgb  (solid_rgb),
      .out_de     (out_de),
      .out_hs     (out_hs),
      .out_vs     (out_vs),
      .out_r      (out_r),
      .out_g      (out_g),
      .out_b      (out_b)
   );

   task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_nf();
      next_frame = 1'b1;
      tick();
      next_frame = 1'b0;
      nf_cnt++;
   endtask

   task automatic vsync();
      in_vs = 1'b0;
      tick();
      tick();
      in_vs = 1'b1;
      tick();
   endtask

   task automatic run_line(input int start, input int len);
      npix = 0;
      for (int c = 0; c < start + len + 4; c++) begin
         if (out_de === 1'b1 && npix < 2048) begin
            pix[npix] = rgb;
            npix++;
         end
         in_de = (c >= start && c < start + len);
         tick();
      end
      in_de = 1'b0;
   endtask

   function automatic logic [7:0] fcount();
      return MOTION ? 8'(nf_cnt % 256) : 8'h00;
   endfunction

   function automatic logic [23:0] chk_exp(input int px, input int py);
      int fc = MOTION ? nf_cnt % 256 : 0;
      return ((((((px + 2 * fc) % 4096) >> 6) ^ (py >> 6)) & 1) != 0) ? 24'h000000 : 24'hFFFFFF;
   endfunction

   initial begin
      reset = 1'b1; in_de = 1'b0; in_hs = 1'b1; in_vs = 1'b1; next_frame = 1'b0;
      pattern_sel = 2'd0; solid_rgb = 24'h123456;
      tick(); tick(); tick();
      check("rst_de", {23'd0, out_de}, 24'd0);
      check("rst_rgb", rgb, 24'h0);
      reset = 1'b0;
      tick();
      check("idle_hs_vs_de", {21'd0, out_hs, out_vs, out_de}, 24'd6);
      tick();
      check("idle_rgb", rgb, 24'h0);
      check("idle_hs_vs_de2", {21'd0, out_hs, out_vs, out_de}, 24'd6);
      in_hs = 1'b0; tick(); in_hs = 1'b1;
      check("hs_lat1", {23'd0, out_hs}, 24'd1);
      tick();
      check("hs_lat2", {23'd0, out_hs}, 24'd0);
      tick();
      check("hs_lat3", {23'd0, out_hs}, 24'd1);

      bad = 0;
      for (int c = 0; c < 1940; c++) begin
         if (out_de !== (c >= 12 && c <= 1931) || rgb !== ((c >= 12 && c <= 1931) ? 24'h123456 : 24'h0)) bad++;
         if (c == 11 || c == 12 || c == 1931 || c == 1932) begin
            check($sformatf("lat_de_%0d", c), {23'd0, out_de}, (c >= 12 && c <= 1931) ? 24'd1 : 24'd0);
            check($sformatf("lat_rgb_%0d", c), rgb, (c >= 12 && c <= 1931) ? 24'h123456 : 24'h0);
         end
         in_de = (c >= 10 && c <= 1929);
         tick();
      end
      check("lat_bad_cycles", 24'(bad), 24'd0);

      pattern_sel = 2'd1; pulse_nf(); vsync();
      run_line(5, 1920);
      check("bars_npix", 24'(npix), 24'd1920);
      check("bars_p0", pix[0], 24'hFFFFFF);
      check("bars_p239", pix[239], 24'hFFFFFF);
      check("bars_p240", pix[240], 24'hFFFF00);
      check("bars_p480", pix[480], 24'h00FFFF);
      check("bars_p1679", pix[1679], 24'h0000FF);
      check("bars_p1680", pix[1680], 24'h000000);
      check("bars_p1919", pix[1919], 24'h000000);

      pattern_sel = 2'd0; pulse_nf(); vsync();
      pattern_sel = 2'd2;
      run_line(5, 100);
      check("sel_hold_p0", pix[0], 24'h123456);
      check("sel_hold_p64", pix[64], 24'h123456);
      pulse_nf(); vsync();
      run_line(5, 200);
      check("chk_p0", pix[0], chk_exp(0, 0));
      check("chk_p63", pix[63], chk_exp(63, 0));
      check("chk_p64", pix[64], chk_exp(64, 0));
      check("chk_p128", pix[128], chk_exp(128, 0));

      pattern_sel = 2'd3; pulse_nf(); vsync();
      for (int l = 0; l < 6; l++) begin
         run_line(3, 400);
         if (l == 0) check("ramp_0_0", pix[0], {8'h00, 8'h00, fcount()});
         if (l == 5) begin
            check("ramp_300_5", pix[300], {8'h2C, 8'h05, fcount()});
            check("ramp_399_5", pix[399], {8'h8F, 8'h05, fcount()});
         end
      end

      vsync();
      run_line(3, 2000);
      check("xsat_npix", 24'(npix), 24'd2000);
      check("xsat_p1919", pix[1919], {8'h7F, 8'h00, fcount()});
      check("xsat_p1999", pix[1999], {8'h7F, 8'h00, fcount()});

      vsync();
      for (int l = 0; l < 1082; l++) begin
         run_line(1, 2);
         if (l == 1079) check("ysat_1079", pix[0], {8'h00, 8'h37, fcount()});
         if (l == 1081) check("ysat_1081", pix[0], {8'h00, 8'h37, fcount()});
      end

      vsync();
      in_de = 1'b1;
      for (int i = 0; i < 50; i++) tick();
      reset = 1'b1; tick(); reset = 1'b0;
      nf_cnt = 0;
      check("mrst_de", {23'd0, out_de}, 24'd0);
      check("mrst_rgb", rgb, 24'h0);
      check("mrst_hs_vs", {22'd0, out_hs, out_vs}, 24'd3);
      for (int i = 0; i < 20; i++) tick();
      in_de = 1'b0;
      tick(); tick(); tick();
      run_line(3, 100);
      check("mrst_solid_p0", pix[0], 24'h123456);
      check("mrst_solid_p99", pix[99], 24'h123456);

`ifdef HDMI_PATTERN_MOTION_EN
      pattern_sel = 2'd2;
      while (nf_cnt < 32) pulse_nf();
      vsync();
      run_line(3, 100);
      check("mot32_p0", pix[0], 24'h000000);
      check("mot32_p0_model", pix[0], chk_exp(0, 0));
      while (nf_cnt < 255) pulse_nf();
      pattern_sel = 2'd3;
      pulse_nf();
      vsync();
      run_line(3, 100);
      check("mot256_ramp_p0", pix[0], 24'h000000);
      check("mot256_ramp_p1", pix[1], 24'h010000);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/hdmi_pattern_gen.md
# hdmi_pattern_gen

Test-pattern generator placed directly downstream of the 1080p60 video timing generator. It consumes the raw DE/HS/VS timing and the `next_frame` pulse and tracks pixel X/Y coordinates. It produces one of four selectable patterns with the timing signals delayed to match, and its outputs drive the HDMI transmitter interface directly.

## Interface
Parameters:
- `H_ACTIVE`, 1920: active pixels per line; X counter width 12 bits.
- `V_ACTIVE`, 1080: active lines per frame; Y counter width 12 bits.
- `BAR_W`, 240: color-bar width in pixels; `H_ACTIVE` must equal 8×`BAR_W`.
- `CHK_LOG2`, 6: checkerboard square size is 2^`CHK_LOG2` pixels.

Ports:
- `hdmi_clk` in 1: pixel clock, the only clock.
- `reset` in 1: synchronous, active-high reset.
- `in_de` in 1: active-video enable from the timing generator.
- `in_hs` in 1: horizontal sync, active low.
- `in_vs` in 1: vertical sync, active low.
- `next_frame` in 1: one-cycle pulse on the last cycle of each frame.
- `pattern_sel` in 2: pattern request. 0 = solid, 1 = bars, 2 = checker, 3 = ramp.
- `solid_rgb` in 24: color for pattern 0, as {R,G,B}.
- `out_de`, `out_hs`, `out_vs` out 1 each: input timing delayed 2 cycles.
- `out_r`, `out_g`, `out_b` out 8 each: pixel color.

## Operation
- **Pattern select:** `pattern_sel` is sampled into `pat_q` only on the cycle where `next_frame`=1. `pattern_sel` changes mid-frame never alter the current frame.
- **X counter (`x`):**
  - 0 on any cycle with `in_de`=0.
  - Increments each `in_de`=1 cycle, so the first active pixel of a line has x=0.
  - Saturates at `H_ACTIVE`-1; a longer DE is treated as malformed timing and does not wrap.
- **Y counter (`y`):**
  - Cleared while `in_vs`=0.
  - Increments on each `in_de` falling edge (registered `de_d`=1 and `in_de`=0).
  - Saturates at `V_ACTIVE`-1.
- **Bar index:**
  - Separate 3-bit `bar` plus a pixel-in-bar counter; no divider.
  - Pixel-in-bar wraps at `BAR_W`-1 and increments `bar`.
  - Both clear when `in_de`=0.
- **Pattern colors:**
  - **0, solid:** `solid_rgb`.
  - **1, bars:** bar 0..7 = white, yellow, cyan, green, magenta, red, blue, black. Component values are 8'hFF or 8'h00.
  - **2, checker:** white if (x'[CHK_LOG2] ^ y[CHK_LOG2]) = 0, else black. x' = x + offset (12-bit, modulo 4096).
  - **3, ramp:** R = x[7:0], G = y[7:0], B = frame count, or 8'h00 when motion is compiled out.
- Outside active video (delayed DE = 0), RGB = 0.
- Reset mid-frame: all state returns to reset values on the next edge. Output restarts cleanly at the next DE rising edge, but Y is wrong until the next VS low.

## Timing
- Stage 1 registers x, y, bar and the delayed timing. Stage 2 registers color and `out_*`.
- Latency is exactly 2 cycles: `out_de/hs/vs`(t+2) = `in_de/hs/vs`(t). Pixel x=N appears on the same cycle as its `out_de`.
- Reset values:
  - `out_de`=0, `out_hs`=1, `out_vs`=1, RGB=0.
  - `pat_q`=0, x=y=bar=0.
  - Frame counter 0.
- `next_frame` coincident with `in_de`=1 (malformed timing): the pattern latch still happens, and counters follow their own rules.

## Configuration
- **`HDMI_PATTERN_MOTION_EN` defined:**
  - 8-bit frame counter increments on each `next_frame` and wraps 255→0.
  - Checker offset = frame count ×2 pixels, giving horizontal scroll.
  - Ramp B = frame count.
- **Undefined:** no frame counter, offset = 0, ramp B = 8'h00. The output is a static image.

## Structure
- **Shared package `video_pkg`:**
  - Pattern enum `pattern_t` (PAT_SOLID, PAT_BARS, PAT_CHECKER, PAT_RAMP).
  - 1080p constants H_ACTIVE/V_ACTIVE.
  - The 8-entry bar color constant array.
- **One sub-module, `pixel_coord`:** holds the x/y/bar counters (stage 1). The top module holds pattern muxing and the delay pipeline.

## Test plan
- **Reset:** hold `reset` 3 cycles, then release with idle timing. `out_hs`=`out_vs`=1, `out_de`=0, RGB=0, and all are stable.
- **Latency:** `pattern_sel`=0, `solid_rgb`=24'h123456, `in_de` high cycles 10–1929. `out_de` is high cycles 12–1931 with RGB=12/34/56 throughout; RGB=0 elsewhere.
- **Bars:** `pattern_sel`=1 latched at `next_frame`. On a line, output pixel 239 = FFFFFF, pixel 240 = FFFF00, pixel 1919 = 000000.
- **Select latching:** change `pattern_sel` 0→2 mid-frame. Output stays solid until after the next `next_frame`; then pixel (0,0) is white and pixel (64,0) is black.
- **Ramp:** `pattern_sel`=3. Pixel (300,5) gives R=8'h2C, G=8'h05, and B=0 when motion is compiled out.
- **Motion (`HDMI_PATTERN_MOTION_EN`):** after 32 `next_frame` pulses, checker pixel (0,0) is black (offset 64). After 256 pulses the frame count is 0 again.
